// File: rtl/mips_pkg.sv
// Shared MIPS fetch/decode definitions: FSM encoding, width defaults,
// the NOP word and the opcode constants used by the decoder and the bench.
package mips_pkg;

  localparam int ADDR_WIDTH_DEF  = 32;
  localparam int INSTR_WIDTH_DEF = 32;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_JUMP   = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_e;

  // Decoder redirect request, only meaningful while an instruction retires.
  typedef struct packed {
    logic jumb;
    logic pc_src;
  } pc_ctrl_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC datapath: PC+4 adder, branch-target adder, jump concatenation and
// the jump-over-branch priority mux. Purely combinational.
module next_pc_logic
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [25:0]           instr_idx,
  input  pc_ctrl_t              ctrl,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  logic [ADDR_WIDTH-1:0] br_off;
  logic [ADDR_WIDTH-1:0] br_target;
  logic [ADDR_WIDTH-1:0] jmp_target;

  assign pc_plus4   = pc + ADDR_WIDTH'(4);
  assign br_off     = {{(ADDR_WIDTH-18){instr_idx[15]}}, instr_idx[15:0], 2'b00};
  assign br_target  = pc_plus4 + br_off;
  // Jump keeps the region bits of the delay-slot address.
  assign jmp_target = {pc_plus4[ADDR_WIDTH-1:28], instr_idx, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (ctrl.jumb)        next_pc = jmp_target;
    else if (ctrl.pc_src) next_pc = br_target;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, IDLE/FETCH/EXEC sequencer and the
// registered instruction to the decoder. FETCH_RETIRE_CNT_EN adds a retire counter.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int                    INSTR_WIDTH  = INSTR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic                   Imem_Req,
  output logic [ADDR_WIDTH-1:0]  Imem_Addr,
  input  logic                   Imem_Ack,
  input  logic [INSTR_WIDTH-1:0] Instr_Rdata,
  input  logic                   Stall,
  input  logic                   PC_src,
  input  logic                   jumb,
  output logic [INSTR_WIDTH-1:0] Instr,
  output logic                   Instr_Valid,
  output logic [ADDR_WIDTH-1:0]  PC,
  output logic [ADDR_WIDTH-1:0]  PC_Plus4,
  output logic [31:0]            Retire_Cnt
);

  localparam logic [ADDR_WIDTH-1:0] RST_PC = {RESET_VECTOR[ADDR_WIDTH-1:2], 2'b00};

  fetch_state_e          state, state_nxt;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  ack_take;
  logic                  retire;
  pc_ctrl_t              ctrl;

  assign ack_take = (state == FETCH) && Imem_Ack;
  assign retire   = (state == EXEC) && !Stall;
  assign ctrl     = '{jumb: jumb, pc_src: PC_src};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (Imem_Ack) state_nxt = EXEC;
      EXEC:    if (!Stall)   state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is a pure state decode so the ack never loops back into it.
  always_comb begin
    Imem_Req    = 1'b0;
    Instr_Valid = 1'b0;
    case (state)
      FETCH:   Imem_Req    = 1'b1;
      EXEC:    Instr_Valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         PC <= RST_PC;
    else if (retire) PC <= next_pc;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           Instr <= INSTR_WIDTH'(NOP);
    else if (ack_take) Instr <= Instr_Rdata;
  end

  assign Imem_Addr = PC;

  next_pc_logic #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc (
    .pc        (PC),
    .instr_idx (Instr[25:0]),
    .ctrl      (ctrl),
    .pc_plus4  (PC_Plus4),
    .next_pc   (next_pc)
  );

`ifdef FETCH_RETIRE_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         Retire_Cnt <= '0;
    else if (retire) Retire_Cnt <= Retire_Cnt + 32'd1;
  end
`else
  assign Retire_Cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, hand-written
// reset/stall/wrap sequences and a randomized run against a reference model.
module tb_pc_fetch_unit;
  import mips_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack = 1'b0;
  logic [31:0] Instr_Rdata = '0;
  logic        Stall = 1'b0;
  logic        PC_src = 1'b0;
  logic        jumb = 1'b0;
  logic [31:0] Instr;
  logic        Instr_Valid;
  logic [31:0] PC;
  logic [31:0] PC_Plus4;
  logic [31:0] Retire_Cnt;

  pc_fetch_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .Imem_Req    (Imem_Req),
    .Imem_Addr   (Imem_Addr),
    .Imem_Ack    (Imem_Ack),
    .Instr_Rdata (Instr_Rdata),
    .Stall       (Stall),
    .PC_src      (PC_src),
    .jumb        (jumb),
    .Instr       (Instr),
    .Instr_Valid (Instr_Valid),
    .PC          (PC),
    .PC_Plus4    (PC_Plus4),
    .Retire_Cnt  (Retire_Cnt)
  );

  always #5 CLK = ~CLK;

`ifdef FETCH_RETIRE_CNT_EN
  localparam logic [31:0] CNT_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CNT_MASK = 32'h0;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  typedef struct {
    logic [31:0] instr;
    bit          src;
    bit          jmp;
    int          ack_dly;
    int          stalls;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference next-PC straight from the ISA rules.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           input bit src, input bit jmp);
    logic [31:0] p4;
    int          off;
    p4  = pc + 32'd4;
    off = 4 * int'($signed(ins[15:0]));
    if (jmp) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (src) return p4 + 32'(off);
    return p4;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; Imem_Ack = 1'b0; Stall = 1'b0; PC_src = 1'b0; jumb = 1'b0;
    #1;
    chk("rst_req", {31'b0, Imem_Req}, 32'd0);
    chk("rst_valid", {31'b0, Instr_Valid}, 32'd0);
    @(negedge CLK);
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", Instr, NOP);
    chk("rst_cnt", Retire_Cnt, 32'h0);
    RST = 1'b0;
    #1;
    chk("idle_req", {31'b0, Imem_Req}, 32'd0);
    @(negedge CLK);
    m_pc  = 32'h0;
    m_ret = 32'h0;
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves at the negedge after retire.
  task automatic run_instr(input logic [31:0] ins, input bit src, input bit jmp,
                           input int ack_dly, input int stalls);
    chk("fetch_req", {31'b0, Imem_Req}, 32'd1);
    chk("fetch_addr", Imem_Addr, m_pc);
    chk("fetch_valid", {31'b0, Instr_Valid}, 32'd0);
    for (int i = 0; i < ack_dly; i++) begin
      Imem_Ack = 1'b0; Instr_Rdata = $urandom;
      Stall = 1'($urandom); PC_src = 1'($urandom); jumb = 1'($urandom);
      @(negedge CLK);
      chk("wait_req", {31'b0, Imem_Req}, 32'd1);
      chk("wait_addr", Imem_Addr, m_pc);
    end
    Imem_Ack = 1'b1; Instr_Rdata = ins;
    Stall = 1'($urandom); PC_src = 1'($urandom); jumb = 1'($urandom);
    @(negedge CLK);
    chk("exec_valid", {31'b0, Instr_Valid}, 32'd1);
    chk("exec_instr", Instr, ins);
    chk("exec_pc", PC, m_pc);
    chk("exec_pc4", PC_Plus4, m_pc + 32'd4);
    chk("exec_req", {31'b0, Imem_Req}, 32'd0);
    chk("exec_cnt", Retire_Cnt, m_ret & CNT_MASK);
    for (int i = 0; i < stalls; i++) begin
      Stall = 1'b1; Imem_Ack = 1'($urandom); Instr_Rdata = $urandom;
      PC_src = 1'($urandom); jumb = 1'($urandom);
      @(negedge CLK);
      chk("stall_instr", Instr, ins);
      chk("stall_pc", PC, m_pc);
      chk("stall_req", {31'b0, Imem_Req}, 32'd0);
      chk("stall_valid", {31'b0, Instr_Valid}, 32'd1);
      chk("stall_cnt", Retire_Cnt, m_ret & CNT_MASK);
    end
    Stall = 1'b0; Imem_Ack = 1'($urandom); Instr_Rdata = $urandom;
    PC_src = src; jumb = jmp;
    @(negedge CLK);
    m_pc  = ref_next(m_pc, ins, src, jmp);
    m_ret = m_ret + 32'd1;
    Imem_Ack = 1'b0; PC_src = 1'b0; jumb = 1'b0;
    chk("retire_cnt", Retire_Cnt, m_ret & CNT_MASK);
    chk("next_req", {31'b0, Imem_Req}, 32'd1);
    chk("next_addr", Imem_Addr, m_pc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           instr         src jmp ack stl next
    vecs[0]  = '{32'h2002_0005, 0, 0, 2, 0, 32'h0000_0004};
    vecs[1]  = '{32'h0800_0004, 0, 1, 0, 0, 32'h0000_0010};
    vecs[2]  = '{32'h0000_0020, 0, 0, 1, 0, 32'h0000_0014};
    vecs[3]  = '{32'h1000_FFFE, 1, 0, 0, 1, 32'h0000_0010};
    vecs[4]  = '{32'h1000_0003, 1, 0, 3, 0, 32'h0000_0020};
    vecs[5]  = '{32'h1000_FFFB, 1, 0, 0, 0, 32'h0000_0010};
    vecs[6]  = '{32'h1000_FFFF, 1, 0, 0, 2, 32'h0000_0010};
    vecs[7]  = '{32'h0BFF_FFFF, 0, 1, 1, 0, 32'h0FFF_FFFC};
    vecs[8]  = '{32'h0800_0002, 1, 1, 0, 0, 32'h1000_0008};
    vecs[9]  = '{32'h0800_0040, 1, 1, 2, 0, 32'h1000_0100};
    vecs[10] = '{32'h1000_0005, 0, 0, 0, 0, 32'h1000_0104};
    vecs[11] = '{32'h0800_0000, 0, 1, 0, 0, 32'h1000_0000};

    do_reset();
    foreach (vecs[i]) begin
      run_instr(vecs[i].instr, vecs[i].src, vecs[i].jmp, vecs[i].ack_dly, vecs[i].stalls);
      chk($sformatf("vec%0d_next", i), Imem_Addr, vecs[i].exp_next);
    end

    // Wrap past the top of the address space, then a 4-cycle stall.
    do_reset();
    run_instr(32'h1000_FFFE, 1'b1, 1'b0, 0, 0);
    chk("wrap_top", Imem_Addr, 32'hFFFF_FFFC);
    run_instr(32'h0000_0020, 1'b0, 1'b0, 1, 4);
    chk("wrap_zero", Imem_Addr, 32'h0000_0000);
    chk("stall_cnt_after", Retire_Cnt, 32'd2 & CNT_MASK);

    // Reset landing on an acked FETCH cycle: the ack must be lost.
    do_reset();
    run_instr(32'h0000_0020, 1'b0, 1'b0, 0, 0);
    Imem_Ack = 1'b1; Instr_Rdata = 32'hDEAD_BEEF; RST = 1'b1;
    #1;
    chk("rstf_req", {31'b0, Imem_Req}, 32'd0);
    @(negedge CLK);
    chk("rstf_instr", Instr, NOP);
    chk("rstf_pc", PC, 32'h0);
    chk("rstf_valid", {31'b0, Instr_Valid}, 32'd0);
    chk("rstf_cnt", Retire_Cnt, 32'h0);
    Imem_Ack = 1'b0; RST = 1'b0;
    #1;
    chk("rstf_idle", {31'b0, Imem_Req}, 32'd0);
    @(negedge CLK);
    m_pc = 32'h0; m_ret = 32'h0;
    chk("rstf_refetch", {31'b0, Imem_Req}, 32'd1);
    chk("rstf_instr2", Instr, NOP);
    run_instr(32'h0800_0010, 1'b0, 1'b1, 0, 0);

    // Reset while executing.
    Imem_Ack = 1'b1; Instr_Rdata = 32'h1234_5678;
    @(negedge CLK);
    Imem_Ack = 1'b0; Stall = 1'b1;
    @(negedge CLK);
    chk("rste_valid_pre", {31'b0, Instr_Valid}, 32'd1);
    RST = 1'b1;
    #1;
    chk("rste_valid", {31'b0, Instr_Valid}, 32'd0);
    chk("rste_pc", PC, 32'h0);
    chk("rste_instr", Instr, NOP);
    Stall = 1'b0;
    @(negedge CLK);
    RST = 1'b0;

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      run_instr(ins, 1'($urandom), 1'($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
